// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: registered-ready pipeline stage with one skid entry and flush.
// Define PIPE_STATS_EN to build the saturating stall/flush statistics counters.
module pipe_stage_skid #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic in_fire, out_fire;
  assign in_ready  = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign out_data  = out_valid ? main_q : NOP_VALUE;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: if (in_fire) begin
        state_d = HALF;
        main_d  = in_data;
      end
      HALF: if (in_fire && out_fire) main_d = in_data;
      else if (in_fire) begin
        state_d = FULL;
        skid_d  = in_data;
      end
      else if (out_fire) state_d = EMPTY;
      FULL: if (out_fire) begin
        state_d = HALF;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    // flush squashes everything, including a payload arriving this cycle
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + CNT_W'(out_valid && !out_ready && stall_q != '1);
      flush_q <= flush_q + CNT_W'(flush && state_q != EMPTY && flush_q != '1);
    end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: table-driven check of the skid stage plus reset and saturation sequences.
module tb_pipe_stage_skid;
`ifdef PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [15:0] stall_cnt, flush_cnt;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [3:0] b_stall_cnt, b_flush_cnt;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  pipe_stage_skid dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  pipe_stage_skid #(.DATA_W(8), .NOP_VALUE(8'h00), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );
  typedef struct {
    logic fl, iv;
    logic [63:0] d;
    logic ordy, ev, er;
    logic [63:0] ed;
    int st, fc;
  } vec_t;
  vec_t vt[$];
  function automatic vec_t mk(logic fl, logic iv, logic [63:0] d, logic ordy,
                              logic ev, logic er, logic [63:0] ed, int st, int fc);
    mk = '{fl, iv, d, ordy, ev, er, ed, st, fc};
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    step; step;
    reset = 0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
    for (int i = 1; i <= 8; i++)
      vt.push_back(mk(0, 1, 64'(i), 1, 1, 1, 64'(i), 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 1, 64'hA, 0, 1, 1, 64'hA, 0, 0));
    vt.push_back(mk(0, 1, 64'hB, 0, 1, 0, 64'hA, 1, 0));
    vt.push_back(mk(0, 1, 64'hC, 0, 1, 0, 64'hA, 2, 0));
    vt.push_back(mk(0, 1, 64'hC, 0, 1, 0, 64'hA, 3, 0));
    vt.push_back(mk(0, 1, 64'hC, 1, 1, 1, 64'hB, 3, 0));
    vt.push_back(mk(0, 1, 64'hC, 1, 1, 1, 64'hC, 3, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 1, 0, 3, 0));
    vt.push_back(mk(0, 1, 64'h11, 0, 1, 1, 64'h11, 3, 0));
    vt.push_back(mk(0, 1, 64'h12, 0, 1, 0, 64'h11, 4, 0));
    vt.push_back(mk(1, 1, 64'hD, 0, 0, 1, 0, 5, 1));
    vt.push_back(mk(0, 0, 64'hD, 0, 0, 1, 0, 5, 1));
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 5, 1));
    vt.push_back(mk(0, 1, 64'h21, 0, 1, 1, 64'h21, 5, 1));
    vt.push_back(mk(1, 1, 64'h22, 1, 0, 1, 0, 5, 2));
    vt.push_back(mk(0, 0, 0, 1, 0, 1, 0, 5, 2));
    vt.push_back(mk(0, 1, 64'h31, 1, 1, 1, 64'h31, 5, 2));
    foreach (vt[i]) begin
      flush = vt[i].fl; in_valid = vt[i].iv; in_data = vt[i].d; out_ready = vt[i].ordy;
      step;
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vt[i].ev));
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vt[i].er));
      chk($sformatf("v%0d_out_data", i), out_data, vt[i].ed);
      chk($sformatf("v%0d_stall_cnt", i), 64'(stall_cnt), STATS ? 64'(vt[i].st) : 64'd0);
      chk($sformatf("v%0d_flush_cnt", i), 64'(flush_cnt), STATS ? 64'(vt[i].fc) : 64'd0);
    end
    flush = 0; in_valid = 1; in_data = 64'h42; out_ready = 0;
    step;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_data", out_data, 64'h31);
    in_valid = 0;
    #2 reset = 1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data", out_data, 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    step;
    reset = 0;
    out_ready = 1;
    step;
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_out_data", out_data, 64'd0);
    b_in_valid = 1; b_in_data = 8'h55; b_out_ready = 0;
    step;
    b_in_valid = 0;
    chk("sat_b_out_data", 64'(b_out_data), 64'h55);
    chk("sat_b_start", 64'(b_stall_cnt), 64'd0);
    for (int i = 0; i < 5; i++) step;
    chk("sat_b_after5", 64'(b_stall_cnt), STATS ? 64'd5 : 64'd0);
    for (int i = 0; i < 15; i++) step;
    chk("sat_b_after20", 64'(b_stall_cnt), STATS ? 64'hF : 64'd0);
    chk("sat_b_flush_cnt", 64'(b_flush_cnt), 64'd0);
    chk("sat_b_still_valid", 64'(b_out_valid), 64'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
